// File: rtl/des_decrypt.sv
// des_decrypt: iterative single-block DES decryption core.
//
// Purpose: one Feistel round per clock with the key schedule run in reverse
// (K16 first). A ciphertext produced by the des encryptor under the same key
// is turned back into its cleartext 17 clocks after the capture edge.
//
// Ports:
//   i_clk         system clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset, priority over everything
//   i_ciphertext  64-bit ciphertext block, DES bit 1 = bit [63]
//   i_key         64-bit key incl. parity bits (byte LSBs are ignored)
//   i_dv          input valid, only sampled while idle
//   o_cleartext   decrypted block, held until the next result
//   o_dv          one-cycle pulse marking a new o_cleartext
//   o_busy        high while a block is in flight
module des_decrypt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_ciphertext,
  input  logic [63:0] i_key,
  input  logic        i_dv,
  output logic [63:0] o_cleartext,
  output logic        o_dv,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  // Permutation tables hold 1-based DES bit numbers, DES bit 1 being the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S-boxes, row-major: entry index is {row(b1,b6), column(b2..b5)}.
  localparam logic [3:0] SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ipPerm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ipPerm[63-i] = x[64-IP_T[i]];
  endfunction

  function automatic logic [63:0] fpPerm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fpPerm[63-i] = x[64-FP_T[i]];
  endfunction

  function automatic logic [47:0] ePerm(input logic [31:0] x);
    for (int i = 0; i < 48; i++) ePerm[47-i] = x[32-E_T[i]];
  endfunction

  function automatic logic [31:0] pPerm(input logic [31:0] x);
    for (int i = 0; i < 32; i++) pPerm[31-i] = x[32-P_T[i]];
  endfunction

  function automatic logic [55:0] pc1Perm(input logic [63:0] x);
    for (int i = 0; i < 56; i++) pc1Perm[55-i] = x[64-PC1_T[i]];
  endfunction

  function automatic logic [47:0] pc2Perm(input logic [55:0] x);
    for (int i = 0; i < 48; i++) pc2Perm[47-i] = x[56-PC2_T[i]];
  endfunction

  // Eight 6-to-4 lookups; the outer bits of each 6-bit group select the row.
  function automatic logic [31:0] sboxSub(input logic [47:0] x);
    logic [5:0] six;
    sboxSub = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      sboxSub[31-4*s -: 4] = SBOX_T[s][{six[5], six[0], six[4:1]}];
    end
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {x[0], x[27:1]};
      2'd2:    rotr = {x[1:0], x[27:2]};
      default: rotr = x;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] lHalf_q, lHalf_d, rHalf_q, rHalf_d;
  logic [27:0] cKey_q, cKey_d, dKey_q, dKey_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] clear_q, clear_d;
  logic        dv_q, dv_d;

  logic [1:0]  rotAmt;
  logic [27:0] cRot, dRot;
  logic [47:0] subkey;
  logic [31:0] fOut;
  logic [63:0] ipIn;
  logic [55:0] pc1Key;

  // Decryption walks the encrypt schedule backwards: round 1 uses the
  // unrotated PC-1 halves (K16), and the single-step rounds mirror the
  // encryptor's single-step rounds 1, 2, 9 and 16.
  always_comb begin
    if (round_q == 5'd1) begin
      rotAmt = 2'd0;
    end else if (round_q == 5'd2 || round_q == 5'd9 || round_q == 5'd16) begin
      rotAmt = 2'd1;
    end else begin
      rotAmt = 2'd2;
    end
  end

  // Shared round datapath: rotated key halves, subkey and Feistel function.
  always_comb begin
    cRot   = rotr(cKey_q, rotAmt);
    dRot   = rotr(dKey_q, rotAmt);
    subkey = pc2Perm({cRot, dRot});
    fOut   = pPerm(sboxSub(ePerm(rHalf_q) ^ subkey));
    ipIn   = ipPerm(i_ciphertext);
    pc1Key = pc1Perm(i_key);
  end

  // Next-state logic: capture in IDLE, sixteen rounds, then publish in DONE.
  always_comb begin
    state_d = state_q;
    lHalf_d = lHalf_q;
    rHalf_d = rHalf_q;
    cKey_d  = cKey_q;
    dKey_d  = dKey_q;
    round_d = round_q;
    clear_d = clear_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dv) begin
          lHalf_d = ipIn[63:32];
          rHalf_d = ipIn[31:0];
          cKey_d  = pc1Key[55:28];
          dKey_d  = pc1Key[27:0];
          round_d = 5'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        cKey_d  = cRot;
        dKey_d  = dRot;
        lHalf_d = rHalf_q;
        rHalf_d = lHalf_q ^ fOut;
        round_d = round_q + 5'd1;
        if (round_q == 5'd16) begin
          state_d = DONE;
        end
      end
      DONE: begin
        clear_d = fpPerm({rHalf_q, lHalf_q});
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any block in flight without a dv pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      lHalf_q <= '0;
      rHalf_q <= '0;
      cKey_q  <= '0;
      dKey_q  <= '0;
      round_q <= '0;
      clear_q <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lHalf_q <= lHalf_d;
      rHalf_q <= rHalf_d;
      cKey_q  <= cKey_d;
      dKey_q  <= dKey_d;
      round_q <= round_d;
      clear_q <= clear_d;
      dv_q    <= dv_d;
    end
  end

  assign o_cleartext = clear_q;
  assign o_dv        = dv_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_des_decrypt.sv
// tb_des_decrypt: self-checking bench for des_decrypt.
//
// Expected cleartexts come from a behavioural DES model (forward key schedule
// with left rotations, subkeys reversed for decryption) plus known vectors.
module tb_des_decrypt;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_ciphertext;
  logic [63:0] i_key;
  logic        i_dv;
  logic [63:0] o_cleartext;
  logic        o_dv;
  logic        o_busy;

  int passCount  = 0;
  int checkCount = 0;

  des_decrypt dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ciphertext (i_ciphertext),
    .i_key        (i_key),
    .i_dv         (i_dv),
    .o_cleartext  (o_cleartext),
    .o_dv         (o_dv),
    .o_busy       (o_busy)
  );

  // Free-running 10 ns clock.
  always #5 i_clk = ~i_clk;

  // Reference tables; FP and E are derived from IP and the E pattern.
  int ipT[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int pT[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  int pc1T[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2T[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int fpT[$];
  int eT[$];
  int shiftT[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sboxT [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Generic table permutation; result is right-aligned in tbl.size() bits.
  function automatic logic [63:0] permBits(input logic [63:0] src, input int srcW, input int tbl[$]);
    logic [63:0] res = '0;
    int n = tbl.size();
    for (int i = 0; i < n; i++) res[n-1-i] = src[srcW - tbl[i]];
    return res;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] twice = {x, x};
    logic [55:0] shifted = twice << n;
    return shifted[55:28];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] e64 = permBits({32'b0, r}, 32, eT);
    logic [47:0] x = e64[47:0] ^ k;
    logic [31:0] s = '0;
    logic [63:0] p64;
    for (int j = 0; j < 8; j++) begin
      int v = int'(x[47-6*j -: 6]);
      int row = ((v >> 4) & 2) | (v & 1);
      int col = (v >> 1) & 15;
      s = (s << 4) | 32'(sboxT[j][row*16 + col]);
    end
    p64 = permBits({32'b0, s}, 32, pT);
    return p64[31:0];
  endfunction

  // Textbook DES: build K1..K16 forward, use them reversed when decrypting.
  function automatic logic [63:0] desModel(input logic [63:0] blk, input logic [63:0] key, input bit decrypt);
    logic [47:0] ks [16];
    logic [63:0] cd64 = permBits(key, 64, pc1T);
    logic [27:0] c = cd64[55:28];
    logic [27:0] d = cd64[27:0];
    logic [63:0] k64, ip;
    logic [31:0] l, r, t;
    for (int i = 0; i < 16; i++) begin
      c = rotl28(c, shiftT[i]);
      d = rotl28(d, shiftT[i]);
      k64 = permBits({8'b0, c, d}, 56, pc2T);
      ks[i] = k64[47:0];
    end
    ip = permBits(blk, 64, ipT);
    l = ip[63:32];
    r = ip[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ feistel(r, decrypt ? ks[15-i] : ks[i]);
      l = t;
    end
    return permBits({r, l}, 64, fpT);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drives one block and checks the result lands exactly 17 edges after the
  // capture edge. pokeCycle>0 re-asserts i_dv with junk just before that edge.
  task automatic applyStimulus(input string tag, input logic [63:0] ct, input logic [63:0] key,
                               input logic [63:0] expected, input bit detailed, input int pokeCycle);
    @(negedge i_clk);
    i_dv = 1'b1;
    i_ciphertext = ct;
    i_key = key;
    @(negedge i_clk);
    i_dv = 1'b0;
    i_ciphertext = {$urandom(), $urandom()};
    i_key = {$urandom(), $urandom()};
    for (int c = 1; c <= 17; c++) begin
      if (detailed) begin
        checkOutput({tag, "_busyWin"}, 64'(o_busy), 64'd1);
        checkOutput({tag, "_dvWin"}, 64'(o_dv), 64'd0);
      end
      i_dv = (c == pokeCycle);
      @(negedge i_clk);
    end
    i_dv = 1'b0;
    checkOutput({tag, "_dv"}, 64'(o_dv), 64'd1);
    checkOutput({tag, "_data"}, o_cleartext, expected);
    if (detailed) begin
      checkOutput({tag, "_busyEnd"}, 64'(o_busy), 64'd0);
      @(negedge i_clk);
      checkOutput({tag, "_dvPulse"}, 64'(o_dv), 64'd0);
      checkOutput({tag, "_hold"}, o_cleartext, expected);
      checkOutput({tag, "_idle"}, 64'(o_busy), 64'd0);
    end
  endtask

  localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] STD_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] STD_PT  = 64'h0123456789ABCDEF;

  logic [63:0] ctHist  [55];
  logic [63:0] keyHist [55];
  logic [63:0] pt, key, ct;
  int          seen;

  initial begin
    // Derived tables: FP is the inverse of IP; E repeats edge bits of each nibble.
    fpT = ipT;
    for (int i = 0; i < 64; i++) fpT[ipT[i]-1] = i + 1;
    for (int j = 0; j < 48; j++) eT.push_back(((4*(j/6) + (j%6) - 1 + 32) % 32) + 1);

    i_rst = 1'b1;
    i_dv = 1'b0;
    i_ciphertext = '0;
    i_key = '0;
    repeat (2) @(negedge i_clk);
    checkOutput("rstData", o_cleartext, 64'd0);
    checkOutput("rstDv", 64'(o_dv), 64'd0);
    checkOutput("rstBusy", 64'(o_busy), 64'd0);
    i_rst = 1'b0;

    applyStimulus("std", STD_CT, STD_KEY, STD_PT, 1'b1, 0);
    applyStimulus("vec2", 64'h0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1, 0);
    applyStimulus("parity", STD_CT, 64'h123556789ABDDEF0, STD_PT, 1'b1, 0);
    applyStimulus("loop", desModel(64'h921a72b60268a21a, 64'hca404e1b3f4f9230, 1'b0),
                  64'hca404e1b3f4f9230, 64'h921a72b60268a21a, 1'b1, 0);
    applyStimulus("poke8", STD_CT, STD_KEY, STD_PT, 1'b1, 8);

    for (int n = 0; n < 1000; n++) begin
      pt  = {$urandom(), $urandom()};
      key = {$urandom(), $urandom()};
      ct  = desModel(pt, key, 1'b0);
      applyStimulus("rand", ct, key, pt, 1'b0, 0);
    end

    // i_dv held high with fresh data every cycle: only every 18th is taken.
    @(negedge i_clk);
    for (int k = 0; k <= 54; k++) begin
      if (k > 0) begin
        checkOutput("contDv", 64'(o_dv), 64'((k % 18) == 0));
        if (k % 18 == 0)
          checkOutput("contData", o_cleartext, desModel(ctHist[k-18], keyHist[k-18], 1'b1));
      end
      if (k < 54) begin
        ctHist[k]  = {$urandom(), $urandom()};
        keyHist[k] = {$urandom(), $urandom()};
        i_dv = 1'b1;
        i_ciphertext = ctHist[k];
        i_key = keyHist[k];
      end else begin
        i_dv = 1'b0;
      end
      @(negedge i_clk);
    end

    // Reset lands on the round-10 edge; the block must vanish silently.
    i_dv = 1'b1;
    i_ciphertext = STD_CT;
    i_key = STD_KEY;
    @(negedge i_clk);
    i_dv = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("abortBusy", 64'(o_busy), 64'd0);
    checkOutput("abortDv", 64'(o_dv), 64'd0);
    checkOutput("abortData", o_cleartext, 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_dv) seen++;
    end
    checkOutput("abortNoPulse", 64'(seen), 64'd0);
    applyStimulus("afterRst", STD_CT, STD_KEY, STD_PT, 1'b1, 0);

    // Reset and valid on the same edge: nothing is captured.
    @(negedge i_clk);
    i_rst = 1'b1;
    i_dv = 1'b1;
    i_ciphertext = STD_CT;
    i_key = STD_KEY;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_dv = 1'b0;
    checkOutput("rstDvBusy", 64'(o_busy), 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_dv || o_busy) seen++;
    end
    checkOutput("rstDvNoCapture", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
